t01_next_piece_sequencer: RTL and testbench

// Sequences the piece supply for the game: 7-bag randomizer (LFSR) feeding a 2-entry queue
// (current, next). Hands pieces to the game FSM via req/valid handshake and drives the 48-bit
// 4x4 preview grid consumed by the lookahead renderer, updated only at frame start (no tearing).

---
 rtl/t01_next_piece_sequencer.sv | 91 +++++++++
 tb/tb_t01_next_piece_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/t01_next_piece_sequencer.sv
// t01_next_piece_sequencer: 7-bag LFSR randomizer feeding a current/next piece queue
// with a frame-synced 4x4 preview grid of the queued piece.
module t01_next_piece_sequencer #(
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int          MAX_TRIES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        seed_load,
   input  logic [15:0] seed_in,
   input  logic        piece_req,
   input  logic        frame_start,
   output logic        piece_valid,
   output logic [2:0]  piece_id,
   output logic [2:0]  next_id,
   output logic [47:0] next_block_data
);
   localparam int TW = $clog2(MAX_TRIES + 1);
   typedef enum logic [1:0] {FILL0, FILL1, READY, REFILL} state_t;
   state_t        state, state_nx;
   logic [15:0]   lfsr, lfsr_step;
   logic [6:0]    mask, mask_set;
   logic [7:0]    used;
   logic [TW-1:0] tries;
   logic [2:0]    cand, fallback, pick;
   logic          draw, pick_done, take, preview_dirty;

   // Cell masks index cells as r*4+c; every lit cell carries colour id+1.
   function automatic logic [47:0] shape(input logic [2:0] id);
      logic [15:0] m;
      logic [47:0] g;
      m = (id == 3'd0) ? 16'h00F0 :
          (id == 3'd1) ? 16'h0660 :
          (id == 3'd2) ? 16'h0270 :
          (id == 3'd3) ? 16'h0360 :
          (id == 3'd4) ? 16'h0630 :
          (id == 3'd5) ? 16'h0470 :
          (id == 3'd6) ? 16'h0170 : 16'h0000;
      g = '0;
      for (int k = 0; k < 16; k++)
         if (m[k]) g[k*3+:3] = id + 3'd1;
      return g;
   endfunction

   // Index 7 is marked permanently used so an out-of-range candidate is rejected.
   always_comb begin
      cand      = lfsr[2:0];
      lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      used      = {1'b1, mask};
      fallback  = 3'd0;
      for (int i = 6; i >= 0; i--)
         if (!mask[i]) fallback = 3'(i);
      draw      = state != READY;
      pick_done = draw && (!used[cand] || tries == TW'(MAX_TRIES));
      pick      = !used[cand] ? cand : fallback;
      mask_set  = mask | (7'd1 << pick);
      take      = state == READY && piece_req;
      state_nx  = pick_done ? (state == FILL0 ? FILL1 : READY) :
                  take      ? REFILL : state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FILL0;
      else     state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr            <= SEED;
         mask            <= '0;
         tries           <= '0;
         piece_valid     <= 1'b0;
         piece_id        <= 3'd0;
         next_id         <= 3'd0;
         next_block_data <= '0;
         preview_dirty   <= 1'b0;
      end else begin
         if (seed_load)  lfsr <= (seed_in == '0) ? SEED : seed_in;
         else if (draw)  lfsr <= lfsr_step;
         if (draw)       tries <= pick_done ? '0 : tries + 1'b1;
         if (pick_done)  mask <= (mask_set == 7'h7F) ? '0 : mask_set;
         if (pick_done && state == FILL0) piece_id <= pick;
         if (take)       piece_id <= next_id;
         if (pick_done && state != FILL0) next_id <= pick;
         piece_valid <= state_nx == READY;
         if (state == READY && frame_start && preview_dirty) next_block_data <= shape(next_id);
         preview_dirty <= (pick_done && state != FILL0) ? 1'b1 :
                          (state == READY && frame_start) ? 1'b0 : preview_dirty;
      end
   end
endmodule

// File: tb/tb_t01_next_piece_sequencer.sv
// tb_t01_next_piece_sequencer: directed scenarios for the piece sequencer with
// hand-derived ids and preview grids from the default seed.
module tb_t01_next_piece_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        seed_load = 1'b0;
   logic [15:0] seed_in = '0;
   logic        piece_req = 1'b0;
   logic        frame_start = 1'b0;
   logic        piece_valid;
   logic [2:0]  piece_id, next_id;
   logic [47:0] next_block_data;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [2:0]  seq [14];
   logic [2:0]  seq_ref [14];
   logic [2:0]  ids [70];

   localparam logic [47:0] SHAPE_I = 48'h000_000_249_000;
   localparam logic [47:0] SHAPE_Z = 48'h000_168_02D_000;

   t01_next_piece_sequencer dut (
      .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
      .piece_req(piece_req), .frame_start(frame_start), .piece_valid(piece_valid),
      .piece_id(piece_id), .next_id(next_id), .next_block_data(next_block_data)
   );

   always #5 clk = ~clk;

   task automatic do_reset;
      rst = 1'b1; piece_req = 1'b0; frame_start = 1'b0; seed_load = 1'b0; seed_in = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!piece_valid && cyc < 40) begin
         step();
         cyc++;
      end
   endtask

   task automatic pulse_req;
      piece_req = 1'b1;
      step();
      piece_req = 1'b0;
   endtask

   task automatic pulse_frame;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic test_reset;
      int cyc;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({piece_valid, piece_id, next_id, next_block_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b id=%0d next=%0d grid=%h, want all 0",
                  piece_valid, piece_id, next_id, next_block_data);
      end
      do_reset();
      wait_valid(cyc);
      n_checks++;
      if (!piece_valid || cyc > 19) begin
         n_fail++;
         $display("FAIL reset_valid_latency: got valid=%b after %0d cycles, want 1 within 19", piece_valid, cyc);
      end
      n_checks++;
      if (piece_id === next_id) begin
         n_fail++;
         $display("FAIL reset_distinct: got id=%0d next=%0d, want different", piece_id, next_id);
      end
      n_checks++;
      if (piece_id !== 3'd1 || next_id !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_first_pair: got id=%0d next=%0d, want 1/0", piece_id, next_id);
      end
      repeat (4) step();
      n_checks++;
      if (next_block_data !== 48'h0) begin
         n_fail++;
         $display("FAIL grid_before_frame: got %h, want 0", next_block_data);
      end
      pulse_frame();
      n_checks++;
      if (next_block_data !== 48'h0000_0024_9000) begin
         n_fail++;
         $display("FAIL grid_i_shape: got %h, want 000000249000", next_block_data);
      end
   endtask

   task automatic test_ignore_req;
      int cyc;
      do_reset();
      wait_valid(cyc);
      pulse_req();
      n_checks++;
      if (piece_id !== 3'd0 || piece_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL req_accept: got id=%0d valid=%b, want 0/0", piece_id, piece_valid);
      end
      pulse_req();
      wait_valid(cyc);
      n_checks++;
      if (!piece_valid || piece_id !== 3'd0 || next_id !== 3'd4) begin
         n_fail++;
         $display("FAIL req_ignored: got valid=%b id=%0d next=%0d, want 1/0/4", piece_valid, piece_id, next_id);
      end
      repeat (5) step();
      n_checks++;
      if (!piece_valid || piece_id !== 3'd0 || next_id !== 3'd4) begin
         n_fail++;
         $display("FAIL req_not_buffered: got valid=%b id=%0d next=%0d, want 1/0/4", piece_valid, piece_id, next_id);
      end
   endtask

   task automatic test_preview_sync;
      int cyc;
      do_reset();
      wait_valid(cyc);
      piece_req = 1'b1; frame_start = 1'b1;
      step();
      piece_req = 1'b0; frame_start = 1'b0;
      n_checks++;
      if (next_block_data !== SHAPE_I) begin
         n_fail++;
         $display("FAIL grid_same_cycle: got %h, want %h", next_block_data, SHAPE_I);
      end
      pulse_frame();
      n_checks++;
      if (next_block_data !== SHAPE_I) begin
         n_fail++;
         $display("FAIL grid_hold_refill: got %h, want %h", next_block_data, SHAPE_I);
      end
      wait_valid(cyc);
      step();
      n_checks++;
      if (next_id !== 3'd4 || next_block_data !== SHAPE_I) begin
         n_fail++;
         $display("FAIL grid_no_frame: got next=%0d grid=%h, want 4/%h", next_id, next_block_data, SHAPE_I);
      end
      pulse_frame();
      n_checks++;
      if (next_block_data !== SHAPE_Z) begin
         n_fail++;
         $display("FAIL grid_z_shape: got %h, want %h", next_block_data, SHAPE_Z);
      end
   endtask

   task automatic test_bag;
      int cyc;
      logic [2:0] prev;
      logic [6:0] seen;
      do_reset();
      wait_valid(cyc);
      ids[0] = piece_id;
      for (int k = 1; k < 70; k++) begin
         prev = next_id;
         pulse_req();
         n_checks++;
         if (piece_id !== prev) begin
            n_fail++;
            $display("FAIL bag_handoff[%0d]: got id=%0d, want %0d", k, piece_id, prev);
         end
         wait_valid(cyc);
         n_checks++;
         if (!piece_valid || cyc > 10) begin
            n_fail++;
            $display("FAIL bag_refill_latency[%0d]: got valid=%b after %0d cycles, want 1 within 10", k, piece_valid, cyc);
         end
         ids[k] = piece_id;
      end
      for (int g = 0; g < 10; g++) begin
         seen = '0;
         for (int j = 0; j < 7; j++)
            if (ids[g*7+j] != 3'd7) seen[ids[g*7+j]] = 1'b1;
         n_checks++;
         if (seen !== 7'h7F) begin
            n_fail++;
            $display("FAIL bag_permutation[%0d]: got mask %b, want 1111111", g, seen);
         end
      end
   endtask

   task automatic collect(input logic [15:0] s);
      int cyc;
      do_reset();
      seed_in = s; seed_load = 1'b1;
      step();
      seed_load = 1'b0;
      wait_valid(cyc);
      seq[0] = piece_id;
      for (int k = 1; k < 14; k++) begin
         pulse_req();
         wait_valid(cyc);
         n_checks++;
         if (!piece_valid) begin
            n_fail++;
            $display("FAIL seed_refill_timeout[%0d]: got valid=0, want 1", k);
         end
         seq[k] = piece_id;
      end
   endtask

   task automatic test_seed;
      collect(16'hACE1);
      seq_ref = seq;
      n_checks++;
      if (seq[0] !== 3'd1 || seq[1] !== 3'd0) begin
         n_fail++;
         $display("FAIL seed_first_pair: got %0d/%0d, want 1/0", seq[0], seq[1]);
      end
      collect(16'h0000);
      for (int k = 0; k < 14; k++) begin
         n_checks++;
         if (seq[k] !== seq_ref[k]) begin
            n_fail++;
            $display("FAIL seed_zero_seq[%0d]: got %0d, want %0d", k, seq[k], seq_ref[k]);
         end
      end
   endtask

   task automatic test_async_reset;
      int cyc;
      do_reset();
      wait_valid(cyc);
      pulse_frame();
      pulse_req();
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({piece_valid, piece_id, next_id, next_block_data} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got valid=%b id=%0d next=%0d grid=%h, want all 0",
                  piece_valid, piece_id, next_id, next_block_data);
      end
      step();
      #1 rst = 1'b0;
      wait_valid(cyc);
      n_checks++;
      if (!piece_valid || piece_id !== 3'd1 || next_id !== 3'd0) begin
         n_fail++;
         $display("FAIL async_restart: got valid=%b id=%0d next=%0d, want 1/1/0", piece_valid, piece_id, next_id);
      end
   endtask

   initial begin
      test_reset();
      test_ignore_req();
      test_preview_sync();
      test_bag();
      test_seed();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
